// File: rtl/tone_period_detector.sv
// Square-wave period detector: measures cycles between input toggles and publishes a locked period.
// Optional deglitch stage between synchronizer and edge detector is enabled by defining GLITCH_FILTER_EN.
module tone_period_detector #(
  parameter int WIDTH          = 24,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 16777215,
  parameter int STABLE_COUNT   = 4,
  parameter int TOLERANCE      = 2,
  parameter int MIN_PERIOD     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             square_wave_in,
  output logic [WIDTH-1:0] tone_period,
  output logic             tone_valid,
  output logic             silent,
  output logic             period_update,
  output logic [1:0]       state_dbg
);

  // Output qualification: tone_period is meaningful only while tone_valid is high; period_update
  // is a single-cycle strobe with no back-pressure, raised in the cycle tone_period takes a new value.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    MEASURING = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  localparam int                 MATCH_W   = $clog2(STABLE_COUNT + 1);
  localparam logic [WIDTH-1:0]   TIMEOUT_V = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0]   ONE_C     = WIDTH'(1);
  localparam logic [WIDTH:0]     ONE_M     = (WIDTH + 1)'(1);
  localparam logic [WIDTH:0]     TOL_V     = (WIDTH + 1)'(TOLERANCE);
  localparam logic [MATCH_W-1:0] STABLE_V  = MATCH_W'(STABLE_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_sync;
  logic                   level;
  logic                   level_d_q;
  logic                   edge_q;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       counter_q, counter_d;
  logic [WIDTH-1:0]       cand_q, cand_d;
  logic [MATCH_W-1:0]     match_q, match_d;
  logic [MATCH_W-1:0]     match_inc;
  logic [WIDTH-1:0]       period_d;
  logic                   valid_d;
  logic                   go_idle;

  logic [WIDTH:0]         meas;
  logic [WIDTH:0]         diff_cand, diff_period;
  logic [WIDTH:0]         abs_cand, abs_period;
  logic                   near_cand, near_period;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], square_wave_in};
    end
  end

  assign level_sync = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
  localparam int              GW          = $clog2(MIN_PERIOD + 1);
  localparam logic [GW-1:0]   GLITCH_LAST = GW'(MIN_PERIOD - 1);

  logic [GW-1:0] glitch_cnt_q;
  logic          filt_q;

  // The filtered level flips only after the synchronized level has disagreed for MIN_PERIOD cycles in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glitch_cnt_q <= '0;
      filt_q       <= 1'b0;
    end else if (level_sync == filt_q) begin
      glitch_cnt_q <= '0;
    end else if (glitch_cnt_q == GLITCH_LAST) begin
      glitch_cnt_q <= '0;
      filt_q       <= level_sync;
    end else begin
      glitch_cnt_q <= glitch_cnt_q + GW'(1);
    end
  end

  assign level = filt_q;
`else
  assign level = level_sync;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_d_q <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      level_d_q <= level;
      edge_q    <= level ^ level_d_q;
    end
  end

  // One bit of headroom keeps the differences from wrapping before the absolute value is taken.
  assign meas        = {1'b0, counter_q} + ONE_M;
  assign diff_cand   = meas - {1'b0, cand_q};
  assign diff_period = meas - {1'b0, tone_period};
  assign abs_cand    = diff_cand[WIDTH]   ? ('0 - diff_cand)   : diff_cand;
  assign abs_period  = diff_period[WIDTH] ? ('0 - diff_period) : diff_period;
  assign near_cand   = (abs_cand <= TOL_V);
  assign near_period = (abs_period <= TOL_V);
  assign match_inc   = match_q + MATCH_ONE;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    cand_d    = cand_q;
    match_d   = match_q;
    period_d  = tone_period;
    valid_d   = tone_valid;
    go_idle   = 1'b0;

    if (counter_q != TIMEOUT_V) begin
      counter_d = counter_q + ONE_C;
    end

    if (!enable) begin
      go_idle   = 1'b1;
      counter_d = '0;
    end else if (edge_q) begin
      counter_d = '0;
      case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          cand_d  = meas[WIDTH-1:0];
          match_d = MATCH_ONE;
          state_d = MEASURING;
        end
        MEASURING: begin
          if (near_cand) begin
            match_d = match_inc;
            if (match_inc == STABLE_V) begin
              state_d  = LOCKED;
              period_d = cand_q;
              valid_d  = 1'b1;
            end
          end else begin
            cand_d  = meas[WIDTH-1:0];
            match_d = MATCH_ONE;
          end
        end
        LOCKED: begin
          // A drifting tone keeps publishing the old period until a fresh lock replaces it.
          if (!near_period) begin
            cand_d  = meas[WIDTH-1:0];
            match_d = MATCH_ONE;
            state_d = MEASURING;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if ((state_q != IDLE) && (counter_d == TIMEOUT_V)) begin
      go_idle = 1'b1;
    end

    if (go_idle) begin
      state_d  = IDLE;
      cand_d   = '0;
      match_d  = '0;
      period_d = '0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      counter_q     <= '0;
      cand_q        <= '0;
      match_q       <= '0;
      tone_period   <= '0;
      tone_valid    <= 1'b0;
      silent        <= 1'b1;
      period_update <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      cand_q        <= cand_d;
      match_q       <= match_d;
      tone_period   <= period_d;
      tone_valid    <= valid_d;
      silent        <= (state_d == IDLE);
      period_update <= (period_d != tone_period);
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_tone_period_detector.sv
// Self-checking bench for tone_period_detector: scoreboard of expected period_update events
// plus per-scenario inline checks of tone_period, tone_valid, silent and state.
module tb_tone_period_detector;

  localparam int WIDTH          = 24;
  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 4096;
  localparam int STABLE_COUNT   = 4;
  localparam int TOLERANCE      = 2;
  localparam int MIN_PERIOD     = 16;
`ifdef GLITCH_FILTER_EN
  localparam int LAT = SYNC_STAGES + 2 + MIN_PERIOD;
`else
  localparam int LAT = SYNC_STAGES + 2;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_MEAS   = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             square_wave_in;
  logic [WIDTH-1:0] tone_period;
  logic             tone_valid;
  logic             silent;
  logic             period_update;
  logic [1:0]       state_dbg;

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  int last_toggle = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               exp_cyc_q[$];

  tone_period_detector #(
    .WIDTH         (WIDTH),
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .STABLE_COUNT  (STABLE_COUNT),
    .TOLERANCE     (TOLERANCE),
    .MIN_PERIOD    (MIN_PERIOD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .square_wave_in(square_wave_in),
    .tone_period   (tone_period),
    .tone_valid    (tone_valid),
    .silent        (silent),
    .period_update (period_update),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every period_update pulse must match the next expected (value, cycle) entry
  always @(negedge clk) begin
    if (rst === 1'b1 && period_update === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pu_unexpected: got tone_period=%0d at cycle %0d, no pulse expected", tone_period, cyc);
      end else begin
        logic [WIDTH-1:0] ep;
        int               ec;
        ep = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if (tone_period !== ep || cyc !== ec) begin
          miscompares++;
          $display("FAIL pu_event: got period=%0d cycle=%0d, want period=%0d cycle=%0d", tone_period, cyc, ep, ec);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic toggle_gap(input int n, input int p);
    for (int i = 0; i < n; i++) begin
      wait_cycles(p);
      square_wave_in = ~square_wave_in;
      last_toggle    = cyc;
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] p, input int c);
    exp_q.push_back(p);
    exp_cyc_q.push_back(c);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    enable         = 1'b1;
    square_wave_in = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic lock_at(input int p);
    toggle_gap(1, 100);
    toggle_gap(3, p);
    toggle_gap(1, p);
    push_exp(WIDTH'(p), last_toggle + LAT);
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drained: got %0d pending pulses, want 0", name, exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    vectors++;
    if (tone_period !== '0 || tone_valid !== 1'b0 || silent !== 1'b1 || period_update !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got period=%0d valid=%b silent=%b pu=%b, want 0 0 1 0",
               tone_period, tone_valid, silent, period_update);
    end
    vectors++;
    if (state_dbg !== S_IDLE) begin
      miscompares++;
      $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE);
    end
    lock_at(1000);
    toggle_gap(1, 1000);
    wait_cycles($urandom_range(100, 800));
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (tone_period !== '0 || tone_valid !== 1'b0 || silent !== 1'b1 || period_update !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got period=%0d valid=%b silent=%b pu=%b, want 0 0 1 0",
               tone_period, tone_valid, silent, period_update);
    end
    square_wave_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    toggle_gap(1, 50);
    wait_cycles(LAT + 1);
    vectors++;
    if (state_dbg !== S_ARMED || silent !== 1'b0 || tone_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rearm: got state=%0d silent=%b valid=%b, want %0d 0 0", state_dbg, silent, tone_valid, S_ARMED);
    end
    check_drained("reset");
  endtask

  task automatic test_lock();
    do_reset();
    toggle_gap(1, 100);
    toggle_gap(3, 1000);
    wait_cycles(LAT + 2);
    vectors++;
    if (state_dbg !== S_MEAS || tone_valid !== 1'b0 || silent !== 1'b0) begin
      miscompares++;
      $display("FAIL prelock: got state=%0d valid=%b silent=%b, want %0d 0 0", state_dbg, tone_valid, silent, S_MEAS);
    end
    toggle_gap(1, 1000 - (LAT + 2));
    push_exp(WIDTH'(1000), last_toggle + LAT);
    wait_cycles(LAT - 1);
    vectors++;
    if (tone_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_early: got valid=%b one cycle before lock, want 0", tone_valid);
    end
    wait_cycles(1);
    vectors++;
    if (tone_valid !== 1'b1 || tone_period !== WIDTH'(1000) || state_dbg !== S_LOCKED || silent !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_1000: got valid=%b period=%0d state=%0d silent=%b, want 1 1000 %0d 0",
               tone_valid, tone_period, state_dbg, silent, S_LOCKED);
    end
    wait_cycles(2);
    check_drained("lock");
  endtask

  // continues from a lock at 1000 with the last toggle LAT+2 cycles ago
  task automatic test_glitch();
    wait_cycles(500 - (LAT + 2));
    square_wave_in = ~square_wave_in;
    toggle_gap(1, 3);
    wait_cycles(10);
`ifdef GLITCH_FILTER_EN
    vectors++;
    if (state_dbg !== S_LOCKED || tone_valid !== 1'b1 || tone_period !== WIDTH'(1000)) begin
      miscompares++;
      $display("FAIL glitch_filtered: got state=%0d valid=%b period=%0d, want %0d 1 1000",
               state_dbg, tone_valid, tone_period, S_LOCKED);
    end
`else
    vectors++;
    if (state_dbg !== S_MEAS || tone_valid !== 1'b1 || tone_period !== WIDTH'(1000)) begin
      miscompares++;
      $display("FAIL glitch_unlock: got state=%0d valid=%b period=%0d, want %0d 1 1000",
               state_dbg, tone_valid, tone_period, S_MEAS);
    end
`endif
    toggle_gap(1, 1000 - 503 - 10);
    toggle_gap(4, 1000);
    wait_cycles(LAT + 2);
    vectors++;
    if (state_dbg !== S_LOCKED || tone_valid !== 1'b1 || tone_period !== WIDTH'(1000)) begin
      miscompares++;
      $display("FAIL glitch_relock: got state=%0d valid=%b period=%0d, want %0d 1 1000",
               state_dbg, tone_valid, tone_period, S_LOCKED);
    end
    check_drained("glitch");
  endtask

  // continues from a lock at 1000; input frozen from here on
  task automatic test_timeout();
    int deadline;
    deadline = last_toggle + LAT + TIMEOUT_CYCLES;
    push_exp('0, deadline);
    wait_cycles(deadline - 1 - cyc);
    vectors++;
    if (tone_valid !== 1'b1 || silent !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got valid=%b silent=%b one cycle before timeout, want 1 0", tone_valid, silent);
    end
    wait_cycles(1);
    vectors++;
    if (tone_valid !== 1'b0 || silent !== 1'b1 || tone_period !== '0 || state_dbg !== S_IDLE) begin
      miscompares++;
      $display("FAIL timeout: got valid=%b silent=%b period=%0d state=%0d, want 0 1 0 %0d",
               tone_valid, silent, tone_period, state_dbg, S_IDLE);
    end
    wait_cycles(2);
    check_drained("timeout");
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    int gap;
    do_reset();
    first  = ($urandom_range(0, 1) == 1) ? 999 : 1001;
    second = 2000 - first;
    toggle_gap(1, 100);
    toggle_gap(1, first);
    toggle_gap(1, second);
    toggle_gap(1, first);
    toggle_gap(1, second);
    push_exp(WIDTH'(first), last_toggle + LAT);
    for (int i = 0; i < 25; i++) begin
      toggle_gap(1, first);
      toggle_gap(1, second);
    end
    wait_cycles(LAT + 2);
    vectors++;
    if (state_dbg !== S_LOCKED || tone_valid !== 1'b1 || tone_period !== WIDTH'(first)) begin
      miscompares++;
      $display("FAIL jitter_lock: got state=%0d valid=%b period=%0d, want %0d 1 %0d",
               state_dbg, tone_valid, tone_period, S_LOCKED, first);
    end
    check_drained("jitter");
    gap = (first == 999) ? 1002 : 998;
    toggle_gap(1, gap - (LAT + 2));
    wait_cycles(LAT + 1);
    vectors++;
    if (state_dbg !== S_MEAS || tone_valid !== 1'b1 || tone_period !== WIDTH'(first)) begin
      miscompares++;
      $display("FAIL tol_edge: got state=%0d valid=%b period=%0d, want %0d 1 %0d",
               state_dbg, tone_valid, tone_period, S_MEAS, first);
    end
  endtask

  task automatic test_switch();
    do_reset();
    lock_at(1000);
    toggle_gap(3, 500);
    wait_cycles(10);
    vectors++;
    if (tone_period !== WIDTH'(1000) || tone_valid !== 1'b1 || state_dbg !== S_MEAS) begin
      miscompares++;
      $display("FAIL switch_hold: got period=%0d valid=%b state=%0d, want 1000 1 %0d",
               tone_period, tone_valid, state_dbg, S_MEAS);
    end
    toggle_gap(1, 490);
    push_exp(WIDTH'(500), last_toggle + LAT);
    wait_cycles(LAT + 2);
    vectors++;
    if (tone_period !== WIDTH'(500) || tone_valid !== 1'b1 || state_dbg !== S_LOCKED) begin
      miscompares++;
      $display("FAIL switch_500: got period=%0d valid=%b state=%0d, want 500 1 %0d",
               tone_period, tone_valid, state_dbg, S_LOCKED);
    end
    push_exp('0, cyc + 1);
    enable = 1'b0;
    wait_cycles(2);
    vectors++;
    if (silent !== 1'b1 || tone_valid !== 1'b0 || tone_period !== '0 || state_dbg !== S_IDLE) begin
      miscompares++;
      $display("FAIL disable: got silent=%b valid=%b period=%0d state=%0d, want 1 0 0 %0d",
               silent, tone_valid, tone_period, state_dbg, S_IDLE);
    end
    toggle_gap(2, 100);
    wait_cycles(LAT + 2);
    vectors++;
    if (state_dbg !== S_IDLE || silent !== 1'b1) begin
      miscompares++;
      $display("FAIL disable_hold: got state=%0d silent=%b, want %0d 1", state_dbg, silent, S_IDLE);
    end
    check_drained("switch");
    enable = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    enable         = 1'b1;
    square_wave_in = 1'b0;
    test_reset();
    test_lock();
    test_glitch();
    test_timeout();
    test_back_to_back();
    test_switch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
